// File: rtl/simon_pkg.sv
// Shared types and timing constants for the Simon game datapath.
package simon_pkg;

    // Two-bit lamp / button code: 0..3 selects one of four lamps.
    typedef logic [1:0] lamp_code_t;

    // Playback engine states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } player_state_t;

    // Default lamp timing at the 10 kHz game clock.
    localparam int LAMP_ON_TICKS  = 3000;   // 300 ms lamp on
    localparam int LAMP_GAP_TICKS = 1000;   // 100 ms dark gap

endpackage

// File: rtl/lamp_fifo.sv
// Small power-of-two FIFO with synchronous flush.
// Pop reads the head entry combinationally; only stored entries can be popped.
module lamp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // Overflow / underflow requests are ignored rather than corrupting state.
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    // Pointer and occupancy next-state; pointers wrap naturally modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers: pointers and occupancy count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/lamp_player.sv
// Simon playback engine: queues lamp codes and plays each one as a timed
// lamp-on interval followed by a dark gap, driving lamps and the tone select.
module lamp_player
    import simon_pkg::*;
#(
    parameter int ON_TICKS  = LAMP_ON_TICKS,
    parameter int GAP_TICKS = LAMP_GAP_TICKS,
    parameter int DEPTH     = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [1:0] CODE,
    input  logic       VALID,
    output logic       READY,
    input  logic       ABORT,
    output logic [3:0] LAMP,
    output logic [1:0] TONE_SEL,
    output logic       TONE_EN,
    output logic       BUSY,
    output logic       DONE
);
    localparam int MAX_TICKS = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
    localparam int TMR_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_TICKS - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_TICKS - 1);

    player_state_t    state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    lamp_code_t       sel_q, sel_d;
    logic [3:0]       lamp_q, lamp_d;
    logic             en_q, en_d;
    logic             done_q, done_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    lamp_code_t       head;

    // READY comes straight from the registered occupancy; ABORT discards pushes.
    assign READY = !fifo_full;
    assign push  = VALID && !fifo_full && !ABORT;

    lamp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .flush_i (ABORT),
        .push_i  (push),
        .data_i  (CODE),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Playback FSM: outputs are computed for the next state so they register
    // in lockstep with it and carry no combinational path from the inputs.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        sel_d   = sel_q;
        lamp_d  = lamp_q;
        en_d    = en_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        if (ABORT) begin
            state_d = IDLE;
            tmr_d   = '0;
            sel_d   = '0;
            lamp_d  = '0;
            en_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ON;
                        tmr_d   = ON_LOAD;
                        sel_d   = head;
                        lamp_d  = 4'b0001 << head;
                        en_d    = 1'b1;
                    end
                end
                ON: begin
                    if (tmr_q == '0) begin
                        state_d = GAP;
                        tmr_d   = GAP_LOAD;
                        lamp_d  = '0;
                        en_d    = 1'b0;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                GAP: begin
                    if (tmr_q != '0) begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end else if (!fifo_empty) begin
                        // Chain straight into the next code with no idle cycle.
                        pop     = 1'b1;
                        state_d = ON;
                        tmr_d   = ON_LOAD;
                        sel_d   = head;
                        lamp_d  = 4'b0001 << head;
                        en_d    = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end
            endcase
        end
    end

    // State, timer and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            sel_q   <= '0;
            lamp_q  <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            sel_q   <= sel_d;
            lamp_q  <= lamp_d;
            en_q    <= en_d;
            done_q  <= done_d;
        end
    end

    assign LAMP     = lamp_q;
    assign TONE_SEL = sel_q;
    assign TONE_EN  = en_q;
    assign DONE     = done_q;
    assign BUSY     = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_lamp_player.sv
// Bench for lamp_player: directed scenarios plus random traffic, checked
// every cycle against a timeline model of the playback rules.
module tb_lamp_player;
    localparam int ON    = 4;
    localparam int GAP   = 2;
    localparam int DEPTH = 2;

    logic       CLK;
    logic       RST_N;
    logic [1:0] CODE;
    logic       VALID;
    logic       READY;
    logic       ABORT;
    logic [3:0] LAMP;
    logic [1:0] TONE_SEL;
    logic       TONE_EN;
    logic       BUSY;
    logic       DONE;

    lamp_player #(
        .ON_TICKS  (ON),
        .GAP_TICKS (GAP),
        .DEPTH     (DEPTH)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CODE     (CODE),
        .VALID    (VALID),
        .READY    (READY),
        .ABORT    (ABORT),
        .LAMP     (LAMP),
        .TONE_SEL (TONE_SEL),
        .TONE_EN  (TONE_EN),
        .BUSY     (BUSY),
        .DONE     (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_asrt = 0;
    int n_fail = 0;
    int n_done = 0;

    // Model: the code queue, plus "cycles elapsed since the current code started".
    logic [1:0] mq[$];
    bit         m_play;
    int         m_el;
    logic [1:0] m_sel;
    bit         m_done;
    bit         m_pushed;

    task automatic model_reset();
        mq.delete();
        m_play = 0; m_el = 0; m_sel = 2'd0; m_done = 0; m_pushed = 0;
    endtask

    task automatic model_edge();
        bit rdy;
        rdy = (mq.size() < DEPTH);
        m_done = 0;
        m_pushed = 0;
        if (!RST_N) begin
            model_reset();
        end else if (ABORT) begin
            mq.delete();
            m_play = 0; m_el = 0; m_sel = 2'd0;
        end else begin
            if (m_play) begin
                m_el++;
                if (m_el == ON + GAP) begin
                    if (mq.size() > 0) begin
                        m_sel = mq.pop_front();
                        m_el  = 0;
                    end else begin
                        m_play = 0;
                        m_done = 1;
                    end
                end
            end else if (mq.size() > 0) begin
                m_sel  = mq.pop_front();
                m_play = 1;
                m_el   = 0;
            end
            if (VALID && rdy) begin
                mq.push_back(CODE);
                m_pushed = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [3:0] e_lamp;
        bit on;
        on = m_play && (m_el < ON);
        e_lamp = on ? (4'b0001 << m_sel) : 4'b0000;
        chk("LAMP", 8'(LAMP), 8'(e_lamp));
        chk("TONE_EN", 8'(TONE_EN), 8'(on));
        chk("TONE_SEL", 8'(TONE_SEL), 8'(m_sel));
        chk("BUSY", 8'(BUSY), 8'(m_play || mq.size() > 0));
        chk("READY", 8'(READY), 8'(mq.size() < DEPTH));
        chk("DONE", 8'(DONE), 8'(m_done));
    endtask

    // One clock: edge, advance the model, then compare just after the edge.
    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check_model();
        if (DONE === 1'b1) n_done++;
    endtask

    task automatic push_one(input logic [1:0] c);
        VALID = 1'b1;
        CODE  = c;
        step();
        VALID = 1'b0;
    endtask

    initial begin
        int done0;
        bit reached;
        RST_N = 1'b0; VALID = 1'b0; ABORT = 1'b0; CODE = 2'd0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_LAMP", 8'(LAMP), 8'h0);
        chk("rst_READY", 8'(READY), 8'h1);
        @(negedge CLK);
        RST_N = 1'b1;

        // Idle after reset.
        repeat (20) step();

        // Single code 2: four ON cycles, two dark, then DONE.
        push_one(2'd2);
        for (int i = 0; i < ON; i++) begin
            step();
            chk("single_on", 8'(LAMP), 8'h04);
        end
        for (int i = 0; i < GAP; i++) begin
            step();
            chk("single_gap", 8'(LAMP), 8'h00);
        end
        step();
        chk("single_done", 8'(DONE), 8'h1);
        step();
        chk("single_done_end", 8'(DONE), 8'h0);

        // Codes 0,3,1 with VALID held; third waits for the first pop.
        done0 = n_done;
        VALID = 1'b1;
        CODE = 2'd0; step();
        CODE = 2'd3; step();
        CODE = 2'd1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (m_pushed) break;
        end
        chk("third_accepted", 8'(m_pushed), 8'h1);
        VALID = 1'b0;
        repeat (3 * (ON + GAP) + 4) step();
        chk("three_done_count", 8'(n_done - done0), 8'h1);

        // Code 3 offered while full must be dropped.
        push_one(2'd1);
        push_one(2'd2);
        push_one(2'd0);
        chk("full_ready", 8'(READY), 8'h0);
        push_one(2'd3);
        repeat (4 * (ON + GAP) + 4) step();

        // ABORT on the second ON cycle with one code queued.
        done0 = n_done;
        push_one(2'd1);
        push_one(2'd2);
        step();
        chk("abort_pre_lamp", 8'(LAMP), 8'h02);
        ABORT = 1'b1;
        step();
        ABORT = 1'b0;
        chk("abort_lamp", 8'(LAMP), 8'h0);
        chk("abort_busy", 8'(BUSY), 8'h0);
        chk("abort_ready", 8'(READY), 8'h1);
        repeat (15) step();
        chk("abort_no_done", 8'(n_done - done0), 8'h0);

        // Random traffic with occasional aborts.
        for (int i = 0; i < 600; i++) begin
            VALID = ($urandom_range(0, 3) == 0);
            CODE  = 2'($urandom_range(0, 3));
            ABORT = ($urandom_range(0, 63) == 0);
            step();
        end
        VALID = 1'b0; ABORT = 1'b0;
        repeat (3 * (ON + GAP)) step();

        // Asynchronous reset in the middle of a GAP.
        push_one(2'd3);
        reached = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (m_play && m_el >= ON) begin
                reached = 1;
                break;
            end
        end
        chk("gap_reached", 8'(reached), 8'h1);
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        chk("arst_LAMP", 8'(LAMP), 8'h0);
        chk("arst_SEL", 8'(TONE_SEL), 8'h0);
        chk("arst_EN", 8'(TONE_EN), 8'h0);
        chk("arst_BUSY", 8'(BUSY), 8'h0);
        chk("arst_DONE", 8'(DONE), 8'h0);
        chk("arst_READY", 8'(READY), 8'h1);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        push_one(2'd1);
        step();
        chk("post_rst_lamp", 8'(LAMP), 8'h02);
        repeat (ON + GAP + 3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
